// File: rtl/mu0_bus_pkg.sv
// Shared bus definitions for the MU0 memory subsystem.
//   master_t : identifies which master (CPU or host) owns a transaction.
//   AW / DW  : default address and data widths, shared by the CPU core,
//              the RAM model and the memory arbiter.
package mu0_bus_pkg;

  typedef enum logic {
    MASTER_CPU  = 1'b0,
    MASTER_HOST = 1'b1
  } master_t;

  localparam int AW = 12;
  localparam int DW = 16;

endpackage

// File: rtl/mu0_rr_pick.sv
// Two-way round-robin picker with a host lock override.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : request vector, bit 0 = CPU, bit 1 = host
//   lock     : host exclusive access; the CPU is never granted while high
//   gnt[1:0] : one-hot combinational grant for the current cycle (0 = none)
// Owns the last_grant pointer, which moves only on cycles with a grant.
module mu0_rr_pick
  import mu0_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt
);

  master_t r_last_grant;

  // Grant selection: reset blocks all grants, lock serves only the host,
  // contention goes to the master not granted most recently.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (lock) begin
      gnt = {req[1], 1'b0};
    end else if (req == 2'b11) begin
      if (r_last_grant == MASTER_HOST) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else begin
      gnt = req;
    end
  end

  // Round-robin pointer; reset to HOST so the CPU wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= MASTER_HOST;
    end else if (gnt[1]) begin
      r_last_grant <= MASTER_HOST;
    end else if (gnt[0]) begin
      r_last_grant <= MASTER_CPU;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Shares one single-port synchronous RAM between the MU0 CPU and a
// host/debug loader port. At most one transaction is granted per cycle;
// the loser sees waitrequest. Read data returns one cycle after the grant
// and is steered to the requester with a readdatavalid strobe.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   c_* (address/read/write/...)  : CPU master port
//   h_* (address/read/write/...)  : host master port
//   h_lock                        : host exclusive access (CPU held off)
//   mem_*                         : RAM command and returned read data
//   grant_host                    : host owns the current cycle
// Commands are not latched: a stalled master must hold its command.
module mu0_mem_arbiter
  import mu0_bus_pkg::*;
#(
  parameter int AW = mu0_bus_pkg::AW,
  parameter int DW = mu0_bus_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] c_address,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [DW-1:0] c_writedata,
  output logic          c_waitrequest,
  output logic [DW-1:0] c_readdata,
  output logic          c_readdatavalid,
  input  logic [AW-1:0] h_address,
  input  logic          h_read,
  input  logic          h_write,
  input  logic [DW-1:0] h_writedata,
  output logic          h_waitrequest,
  output logic [DW-1:0] h_readdata,
  output logic          h_readdatavalid,
  input  logic          h_lock,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_writedata,
  input  logic [DW-1:0] mem_readdata,
  output logic          grant_host
);

  logic          w_c_req;
  logic          w_h_req;
  logic [1:0]    w_gnt;
  logic [AW-1:0] w_mem_address;
  logic          w_mem_read;
  logic          w_mem_write;
  logic [DW-1:0] w_mem_writedata;

  logic          r_rsp_valid;
  master_t       r_rsp_id;

  assign w_c_req = c_read | c_write;
  assign w_h_req = h_read | h_write;

  mu0_rr_pick u_pick (
    .clk  (clk),
    .rst  (rst),
    .req  ({w_h_req, w_c_req}),
    .lock (h_lock),
    .gnt  (w_gnt)
  );

  // Command mux onto the RAM; write dominates when a master raises both
  // strobes, so no read (and no response) is issued for that command.
  always_comb begin
    w_mem_address   = {AW{1'b0}};
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_writedata = {DW{1'b0}};
    if (w_gnt[1]) begin
      w_mem_address   = h_address;
      w_mem_read      = h_read & ~h_write;
      w_mem_write     = h_write;
      w_mem_writedata = h_writedata;
    end else if (w_gnt[0]) begin
      w_mem_address   = c_address;
      w_mem_read      = c_read & ~c_write;
      w_mem_write     = c_write;
      w_mem_writedata = c_writedata;
    end else begin
      w_mem_address   = {AW{1'b0}};
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_mem_writedata = {DW{1'b0}};
    end
  end

  // Read response pipeline: remembers who issued the read one cycle ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= MASTER_CPU;
    end else begin
      r_rsp_valid <= w_mem_read;
      r_rsp_id    <= w_gnt[1] ? MASTER_HOST : MASTER_CPU;
    end
  end

  assign mem_address   = w_mem_address;
  assign mem_read      = w_mem_read;
  assign mem_write     = w_mem_write;
  assign mem_writedata = w_mem_writedata;
  assign grant_host    = w_gnt[1];

  // During reset both ports stall regardless of what they request.
  assign c_waitrequest = rst | (w_c_req & ~w_gnt[0]);
  assign h_waitrequest = rst | (w_h_req & ~w_gnt[1]);

  // A response already in flight is still delivered during a reset cycle.
  assign c_readdata      = mem_readdata;
  assign h_readdata      = mem_readdata;
  assign c_readdatavalid = r_rsp_valid & (r_rsp_id == MASTER_CPU);
  assign h_readdatavalid = r_rsp_valid & (r_rsp_id == MASTER_HOST);

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: cycle table with hand-derived expectations,
// a shadow RAM supplying expected read data, and a response scoreboard.
module tb_mu0_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] c_address, h_address, mem_address;
  logic        c_read, c_write, h_read, h_write, h_lock;
  logic [15:0] c_writedata, h_writedata, mem_writedata;
  logic        c_waitrequest, h_waitrequest, c_readdatavalid, h_readdatavalid;
  logic [15:0] c_readdata, h_readdata;
  logic        mem_read, mem_write, grant_host;
  logic [15:0] mem_readdata = 16'h0000;

  always #5 clk = ~clk;

  mu0_mem_arbiter #(.AW(12), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .c_address(c_address), .c_read(c_read), .c_write(c_write),
    .c_writedata(c_writedata), .c_waitrequest(c_waitrequest),
    .c_readdata(c_readdata), .c_readdatavalid(c_readdatavalid),
    .h_address(h_address), .h_read(h_read), .h_write(h_write),
    .h_writedata(h_writedata), .h_waitrequest(h_waitrequest),
    .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
    .h_lock(h_lock),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .grant_host(grant_host)
  );

  // RAM model (driven by the DUT) and independent shadow copy (bench side)
  logic [15:0] ram [0:4095];
  logic [15:0] exp_ram [0:4095];

  always @(posedge clk) begin
    if (mem_write === 1'b1) ram[mem_address] <= mem_writedata;
    if (mem_read === 1'b1) mem_readdata <= ram[mem_address];
  end

  int n_crdv = 0;
  int n_hrdv = 0;
  always @(negedge clk) begin
    if (c_readdatavalid === 1'b1) n_crdv++;
    if (h_readdatavalid === 1'b1) n_hrdv++;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ctl = {rst, h_lock, c_read, c_write, h_read, h_write}
  // ex  = {c_waitrequest, h_waitrequest, grant_host, mem_read, mem_write}
  typedef struct {
    string       nm;
    logic [5:0]  ctl;
    logic [11:0] ca;
    logic [15:0] cd;
    logic [11:0] ha;
    logic [15:0] hd;
    logic [4:0]  ex;
    logic [11:0] ema;
    logic [15:0] emd;
  } vec_t;

  typedef struct {
    logic        host;
    logic [15:0] data;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];

  task automatic add(input string nm, input logic [5:0] ctl, input logic [11:0] ca,
                     input logic [15:0] cd, input logic [11:0] ha, input logic [15:0] hd,
                     input logic [4:0] ex, input logic [11:0] ema, input logic [15:0] emd);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.ca = ca; v.cd = cd; v.ha = ha; v.hd = hd;
    v.ex = ex; v.ema = ema; v.emd = emd;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    {rst, h_lock, c_read, c_write, h_read, h_write} = 6'b000000;
    c_address = 12'h000; c_writedata = 16'h0000;
    h_address = 12'h000; h_writedata = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c_done, h_done;
    rsp_t r;
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 16'hA000 ^ 16'(i);
      exp_ram[i] = 16'hA000 ^ 16'(i);
    end
    ram[12'h010] = 16'h7000;
    exp_ram[12'h010] = 16'h7000;

    //   name        ctl        ca      cd       ha      hd       ex        ema     emd
    add("rst_idle", 6'b100000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b11000, 12'h000, 16'h0000);
    add("rst_req",  6'b101010, 12'h050, 16'h0000, 12'h060, 16'h0000, 5'b11000, 12'h000, 16'h0000);
    add("c_alone",  6'b001000, 12'h010, 16'h0000, 12'h000, 16'h0000, 5'b00010, 12'h010, 16'h0000);
    add("c_rsp",    6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);
    add("rst2",     6'b100000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b11000, 12'h000, 16'h0000);
    add("cont_c",   6'b001001, 12'h001, 16'h0000, 12'h020, 16'hBEEF, 5'b01010, 12'h001, 16'h0000);
    add("cont_h",   6'b000001, 12'h000, 16'h0000, 12'h020, 16'hBEEF, 5'b00101, 12'h020, 16'hBEEF);
    add("idle1",    6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);
    add("rr0",      6'b001010, 12'h100, 16'h0000, 12'h200, 16'h0000, 5'b01010, 12'h100, 16'h0000);
    add("rr1",      6'b001010, 12'h101, 16'h0000, 12'h200, 16'h0000, 5'b10110, 12'h200, 16'h0000);
    add("rr2",      6'b001010, 12'h101, 16'h0000, 12'h201, 16'h0000, 5'b01010, 12'h101, 16'h0000);
    add("rr3",      6'b001010, 12'h102, 16'h0000, 12'h201, 16'h0000, 5'b10110, 12'h201, 16'h0000);
    add("rr4",      6'b001010, 12'h102, 16'h0000, 12'h202, 16'h0000, 5'b01010, 12'h102, 16'h0000);
    add("rr5",      6'b001010, 12'h103, 16'h0000, 12'h202, 16'h0000, 5'b10110, 12'h202, 16'h0000);
    add("rr6",      6'b001010, 12'h103, 16'h0000, 12'h203, 16'h0000, 5'b01010, 12'h103, 16'h0000);
    add("rr7",      6'b000010, 12'h000, 16'h0000, 12'h203, 16'h0000, 5'b00110, 12'h203, 16'h0000);
    add("idle2",    6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);
    add("lk0",      6'b011001, 12'h300, 16'h0000, 12'h000, 16'h1111, 5'b10101, 12'h000, 16'h1111);
    add("lk1",      6'b011001, 12'h300, 16'h0000, 12'h001, 16'h2222, 5'b10101, 12'h001, 16'h2222);
    add("lk2",      6'b011001, 12'h300, 16'h0000, 12'h002, 16'h3333, 5'b10101, 12'h002, 16'h3333);
    add("lk3",      6'b011001, 12'h300, 16'h0000, 12'h003, 16'h4444, 5'b10101, 12'h003, 16'h4444);
    add("lk_hidle", 6'b011000, 12'h300, 16'h0000, 12'h000, 16'h0000, 5'b10000, 12'h000, 16'h0000);
    add("unlock",   6'b001000, 12'h300, 16'h0000, 12'h000, 16'h0000, 5'b00010, 12'h300, 16'h0000);
    add("lk_pend",  6'b011010, 12'h301, 16'h0000, 12'h002, 16'h0000, 5'b10110, 12'h002, 16'h0000);
    add("idle3",    6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);
    add("c_rw",     6'b001100, 12'h030, 16'h1234, 12'h000, 16'h0000, 5'b00001, 12'h030, 16'h1234);
    add("idle4",    6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);
    add("h_rd030",  6'b000010, 12'h000, 16'h0000, 12'h030, 16'h0000, 5'b00110, 12'h030, 16'h0000);
    add("idle5",    6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);
    add("h_rd005",  6'b000010, 12'h000, 16'h0000, 12'h005, 16'h0000, 5'b00110, 12'h005, 16'h0000);
    add("rst_mid",  6'b101010, 12'h006, 16'h0000, 12'h007, 16'h0000, 5'b11000, 12'h000, 16'h0000);
    add("post_rst", 6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);
    add("cont2_c",  6'b000101, 12'h050, 16'h0A0A, 12'h051, 16'h0B0B, 5'b01001, 12'h050, 16'h0A0A);
    add("cont2_h",  6'b000001, 12'h000, 16'h0000, 12'h051, 16'h0B0B, 5'b00101, 12'h051, 16'h0B0B);
    add("idle6",    6'b000000, 12'h000, 16'h0000, 12'h000, 16'h0000, 5'b00000, 12'h000, 16'h0000);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic ecw, ehw, egh, emr, emw;
      v = vecs[i];
      {ecw, ehw, egh, emr, emw} = v.ex;
      @(posedge clk);
      #1;
      {rst, h_lock, c_read, c_write, h_read, h_write} = v.ctl;
      c_address = v.ca; c_writedata = v.cd;
      h_address = v.ha; h_writedata = v.hd;
      #6;
      // response scoreboard: a read granted last cycle answers now
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk({v.nm, "_c_rdv"}, 32'(c_readdatavalid), 32'(!r.host));
        chk({v.nm, "_h_rdv"}, 32'(h_readdatavalid), 32'(r.host));
        chk({v.nm, "_rdata"}, 32'(r.host ? h_readdata : c_readdata), 32'(r.data));
      end else begin
        chk({v.nm, "_no_rdv"}, 32'({c_readdatavalid, h_readdatavalid}), 32'(2'b00));
      end
      chk({v.nm, "_c_wait"}, 32'(c_waitrequest), 32'(ecw));
      chk({v.nm, "_h_wait"}, 32'(h_waitrequest), 32'(ehw));
      chk({v.nm, "_gnt_h"}, 32'(grant_host), 32'(egh));
      chk({v.nm, "_strobes"}, 32'({mem_read, mem_write}), 32'({emr, emw}));
      chk({v.nm, "_addr"}, 32'(mem_address), 32'(v.ema));
      chk({v.nm, "_wdata"}, 32'(mem_writedata), 32'(v.emd));
      if (emr) begin
        r.host = egh;
        r.data = exp_ram[v.ema];
        sb.push_back(r);
      end
      if (emw) exp_ram[v.ema] = v.emd;
    end

    // Hand sequence: simultaneous writes, each must finish within a budget
    c_done = 1'b0;
    h_done = 1'b0;
    for (int cyc = 0; cyc < 4 && !(c_done && h_done); cyc++) begin
      @(posedge clk);
      #1;
      drive_idle();
      c_write = !c_done; c_address = 12'h040; c_writedata = 16'h5A5A;
      h_write = !h_done; h_address = 12'h041; h_writedata = 16'hA5A5;
      #6;
      if (!c_done && !h_done)
        chk("hs_one_winner", 32'(c_waitrequest ^ h_waitrequest), 32'd1);
      if (!c_done && c_waitrequest === 1'b0) c_done = 1'b1;
      else if (!h_done && h_waitrequest === 1'b0) h_done = 1'b1;
    end
    chk("hs_c_done", 32'(c_done), 32'd1);
    chk("hs_h_done", 32'(h_done), 32'd1);
    @(posedge clk);
    #1;
    drive_idle();
    #6;

    chk("ram_020", 32'(ram[12'h020]), 32'h0000BEEF);
    chk("ram_000", 32'(ram[12'h000]), 32'h00001111);
    chk("ram_003", 32'(ram[12'h003]), 32'h00004444);
    chk("ram_030", 32'(ram[12'h030]), 32'h00001234);
    chk("ram_050", 32'(ram[12'h050]), 32'h00000A0A);
    chk("ram_051", 32'(ram[12'h051]), 32'h00000B0B);
    chk("ram_040", 32'(ram[12'h040]), 32'h00005A5A);
    chk("ram_041", 32'(ram[12'h041]), 32'h0000A5A5);
    chk("c_rdv_pulses", 32'(n_crdv), 32'd7);
    chk("h_rdv_pulses", 32'(n_hrdv), 32'd7);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mu0_mem_arbiter.md
# mu0_mem_arbiter

Two-master arbiter that shares one single-port synchronous program/data RAM between the MU0 CPU and a host/debug loader port. It grants at most one memory transaction per cycle and routes the one-cycle-latency read response back to the requester. It stalls the loser with `waitrequest`. A host lock gives the host exclusive access for program loading or memory inspection while the CPU is held off.

## Interface

Parameters:
- `AW`, 12: address width, matching the MU0 12-bit address space.
- `DW`, 16: data width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `c_address`, in, AW: CPU address.
- `c_read`, `c_write`, in, 1 each: CPU requests.
- `c_writedata`, in, DW: CPU write data.
- `c_waitrequest`, out, 1: CPU stalled; the CPU must hold its command stable.
- `c_readdata`, out, DW: read data, equal to `mem_readdata`.
- `c_readdatavalid`, out, 1: CPU read response strobe.
- `h_address`, `h_read`, `h_write`, `h_writedata`, `h_waitrequest`, `h_readdata`, `h_readdatavalid`: host port, same meanings as the CPU port.
- `h_lock`, in, 1: host exclusive-access request.
- `mem_address`, out, AW: RAM address.
- `mem_read`, `mem_write`, out, 1 each: RAM strobes.
- `mem_writedata`, out, DW: RAM write data.
- `mem_readdata`, in, DW: RAM data, valid the cycle after `mem_read`.
- `grant_host`, out, 1: the host owns the current cycle (debug/visibility).

## Operation

- A master is requesting when its `read` or `write` is high. If both are high, it is a write; no read is issued and no `readdatavalid` follows.
- Each cycle, the arbiter grants at most one requesting master. The grant is combinational in that cycle.
  - The granted master sees `waitrequest` = 0, and its address, data and strobe drive `mem_*`.
  - A requesting master that is not granted sees `waitrequest` = 1.
  - A non-requesting master sees `waitrequest` = 0 (don't-care).
- Arbitration:
  - `rst` high: no grant. Both `waitrequest` = 1 and `mem_read` = `mem_write` = 0.
  - `h_lock` high: the CPU is never granted; the host is granted whenever it requests. The lock takes effect in the same cycle it is asserted and releases in the same cycle it is deasserted.
  - Only one master requesting: that master is granted.
  - Both requesting, no lock: round-robin. The master not granted most recently wins.
- The round-robin pointer `last_grant` updates only on cycles with a grant. Reset value is HOST, so the CPU wins the first contention.
- Read response:
  - On a granted read, register `rsp_valid` = 1 and `rsp_id` = the winner.
  - Next cycle, assert the matching `*_readdatavalid` for exactly one cycle.
  - Back-to-back reads, including alternating masters, are supported at one per cycle.
- Writes produce no response. A granted write completes at the clock edge ending the grant cycle.
- With no grant, `mem_address` = 0, `mem_writedata` = 0 and both strobes are 0.

## Timing

- Reset values (registered):
  - `last_grant` = HOST.
  - `rsp_valid` = 0, so `c_readdatavalid` = `h_readdatavalid` = 0.
- Output values while `rst` is high (combinational gating): `c_waitrequest` = `h_waitrequest` = 1 and `grant_host` = 0.
- Uncontended access has zero-cycle grant latency. Read data arrives one cycle after the grant.
- Under continuous contention with no lock, each master gets every other cycle. Worst-case CPU stall is 1 cycle per access.
- Reset mid-operation:
  - A read granted in cycle N with `rst` high in cycle N+1 still delivers `readdatavalid` in N+1.
  - The edge ending N+1 then clears it.
  - No new grant occurs while `rst` is high.
- Lock asserted while a CPU read response is pending: the response is still delivered to the CPU.
- A master must not change its command while its `waitrequest` is 1. The arbiter does not latch commands.

## Structure

- Package `mu0_bus_pkg`:
  - `typedef enum logic {MASTER_CPU = 1'b0, MASTER_HOST = 1'b1} master_t`.
  - `AW`/`DW` default constants, shared with the CPU core and the RAM model.
- Sub-module `mu0_rr_pick`:
  - Inputs: `clk`, `rst`, `req[1:0]`, `lock`.
  - Outputs: one-hot `gnt[1:0]`.
  - Owns the `last_grant` register.
- The response pipeline (`rsp_valid`, `rsp_id`) and the command muxing stay in `mu0_mem_arbiter`.

## Test plan

- After `rst`, CPU reads 0x010 alone, RAM[0x010]=0x7000 → `c_waitrequest`=0 in the same cycle; `c_readdatavalid`=1 with `c_readdata`=0x7000 one cycle later; the host port is silent.
- CPU read 0x001 and host write 0x020←0xBEEF in the same cycle, first contention → CPU granted, host stalled 1 cycle then granted; RAM[0x020]=0xBEEF; exactly one `c_readdatavalid`.
- Both masters issue 4 reads each continuously → grants alternate C,H,C,H,…; each master gets 4 `readdatavalid` pulses with correct data; no overlap.
- `h_lock`=1 with the CPU requesting throughout, host writes 0x000–0x003 → `c_waitrequest`=1 for the whole lock; writes land in RAM; the CPU is granted on the first cycle after `h_lock` falls.
- Host read of 0x005 granted in cycle N, `rst` pulsed in N+1 → `h_readdatavalid`=1 in N+1, 0 afterwards; no `mem_*` strobes in N+1; the first contention after reset goes to the CPU.
- `c_read`=`c_write`=1 at 0x030, data 0x1234 → RAM[0x030]=0x1234; no `c_readdatavalid`.
